// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity generator.
// The state encoding lives here so every user of the generator sees the same enum.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int EVEN_PAR = 0;
    localparam int ODD_PAR  = 1;

endpackage

// File: rtl/parity_generator.sv
// Serialises a DATA_W-bit word LSB first and appends a parity bit flagged by x_last.
// Every bit is held on x until x_valid && x_ready; one IDLE cycle separates frames.
//
//   state  | meaning
//   IDLE   | waiting for din_valid; x and x_valid low
//   DATA   | presenting captured data bits, LSB first
//   PARITY | presenting the parity bit with x_last high
module parity_generator
    import parity_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PAR_ODD = EVEN_PAR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              x,
    output logic              x_valid,
    input  logic              x_ready,
    output logic              x_last
);

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic              PAR_INIT = 1'(PAR_ODD);

    if (DATA_W < 2 || DATA_W > 32) begin : g_bad_width
        $error("parity_generator: DATA_W must be in 2..32");
    end

    state_t            state_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              par_q;
    logic              x_q;
    logic              x_valid_q;
    logic              x_last_q;

    assign din_ready = (state_q == IDLE) && !reset;
    assign shift_d   = shift_q >> 1;
    assign cnt_d     = cnt_q + 1'b1;

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign x_last  = x_last_q;

    // Parity is resolved at capture time so the PARITY state only has to present it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            par_q     <= 1'b0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            x_last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (din_valid && din_ready) begin
                        shift_q   <= din;
                        cnt_q     <= '0;
                        par_q     <= (^din) ^ PAR_INIT;
                        x_q       <= din[0];
                        x_valid_q <= 1'b1;
                        x_last_q  <= 1'b0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (x_ready) begin
                        if (cnt_q == CNT_LAST) begin
                            x_q      <= par_q;
                            x_last_q <= 1'b1;
                            state_q  <= PARITY;
                        end else begin
                            cnt_q   <= cnt_d;
                            shift_q <= shift_d;
                            x_q     <= shift_d[0];
                        end
                    end
                end
                PARITY: begin
                    if (x_ready) begin
                        shift_q   <= '0;
                        cnt_q     <= '0;
                        par_q     <= 1'b0;
                        x_q       <= 1'b0;
                        x_valid_q <= 1'b0;
                        x_last_q  <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    x_q       <= 1'b0;
                    x_valid_q <= 1'b0;
                    x_last_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_generator.sv
// Scoreboard bench: an even-mode and an odd-mode generator share one stimulus stream;
// expected bit streams come from a word-level model and a loopback parity checker.
module tb_parity_generator;
    import parity_pkg::*;

    logic       clk;
    logic       reset;
    logic [7:0] din;
    logic       din_valid;
    logic       x_ready;
    logic [1:0] x_w, xv_w, xl_w, dr_w;

    logic [1:0] q_e[$];
    logic [1:0] q_o[$];
    logic [1:0] prev_stall;
    logic [2:0] prev_bits [2];
    logic [1:0] acc;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int rdy_mode = 0;

    parity_generator #(.DATA_W(8), .PAR_ODD(EVEN_PAR)) dut_e (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(dr_w[0]),
        .x(x_w[0]), .x_valid(xv_w[0]), .x_ready(x_ready), .x_last(xl_w[0])
    );

    parity_generator #(.DATA_W(8), .PAR_ODD(ODD_PAR)) dut_o (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(dr_w[1]),
        .x(x_w[1]), .x_valid(xv_w[1]), .x_ready(x_ready), .x_last(xl_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // 0: ready held high, 1: random backpressure, 2: forced stall
    initial begin
        x_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       x_ready = ($urandom_range(0, 3) != 0);
                2:       x_ready = 1'b0;
                default: x_ready = 1'b1;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, req, cyc);
        end
    endtask

    task automatic check_lane(input int k);
        logic       xx, xv, xl, empty;
        logic [1:0] e;
        xx = x_w[k];
        xv = xv_w[k];
        xl = xl_w[k];
        empty = 1'b0;
        e = '0;
        if (prev_stall[k])
            chk($sformatf("hold%0d", k), {xv, xx, xl}, prev_bits[k]);
        if (xv && x_ready) begin
            if (k == 0) begin
                if (q_e.size() == 0) empty = 1'b1; else e = q_e.pop_front();
            end else begin
                if (q_o.size() == 0) empty = 1'b1; else e = q_o.pop_front();
            end
            if (empty)
                chk($sformatf("unexpected%0d", k), {xx, xl}, 2'b11 ^ {xx, xl});
            else
                chk($sformatf("bit%0d", k), {xx, xl}, e);
            acc[k] = acc[k] ^ xx;
            if (xl) begin
                chk($sformatf("loopback%0d", k), acc[k], k);
                acc[k] = 1'b0;
            end
        end else if (!xv) begin
            chk($sformatf("idle%0d", k), {xx, xl}, 2'b00);
        end
        prev_stall[k] = xv && !x_ready;
        prev_bits[k]  = {1'b1, xx, xl};
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) check_lane(k);
        end
    end

    task automatic push_word(input logic [7:0] w);
        logic p;
        p = logic'($countones(w) % 2);
        for (int i = 0; i < 8; i++) begin
            q_e.push_back({w[i], 1'b0});
            q_o.push_back({w[i], 1'b0});
        end
        q_e.push_back({p, 1'b1});
        q_o.push_back({~p, 1'b1});
    endtask

    task automatic send(input logic [7:0] w);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        din = w;
        din_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (dr_w == 2'b11) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            chk("accept_timeout", 0, 1);
            din_valid = 1'b0;
        end else begin
            push_word(w);
            acc_cyc = cyc;
            @(posedge clk);
            #1;
            din_valid = 1'b0;
            din = 8'($urandom);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_din_ready", dr_w, 2'b00);
        @(posedge clk);
        #1;
        q_e.delete();
        q_o.delete();
        prev_stall = '0;
        acc = '0;
        chk("rst_x_valid", xv_w, 2'b00);
        chk("rst_x_last", xl_w, 2'b00);
        chk("rst_x", x_w, 2'b00);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_din_ready", dr_w, 2'b11);
    endtask

    initial begin
        bit ok;
        din = '0;
        din_valid = 1'b0;
        reset = 1'b1;
        prev_stall = '0;
        acc = '0;
        prev_bits[0] = '0;
        prev_bits[1] = '0;
        do_reset();

        // 0xA5: latency 1 and din_ready back 10 cycles after accept
        send(8'hA5);
        @(negedge clk);
        chk("first_bit_valid", xv_w, 2'b11);
        chk("first_bit_x", x_w, 2'b11);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (dr_w == 2'b11) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("ready_again_found", ok, 1);
        chk("frame_period", cyc - acc_cyc, 10);

        send(8'h07);
        send(8'h00);

        // 0x3C with bit 3 stalled for three cycles
        send(8'h3C);
        repeat (3) @(negedge clk);
        rdy_mode = 2;
        repeat (3) @(negedge clk);
        rdy_mode = 0;

        // 0xFF offered while a 0x01 frame is in flight must be ignored
        send(8'h01);
        din = 8'hFF;
        din_valid = 1'b1;
        @(negedge clk);
        chk("busy_din_ready_a", dr_w, 2'b00);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("busy_din_ready_b", dr_w, 2'b00);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        send(8'hFF);

        // reset in the middle of a 0x5A frame, then a clean 0x81 frame
        send(8'h5A);
        repeat (4) @(posedge clk);
        do_reset();
        send(8'h81);

        rdy_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send(8'($urandom));
        end

        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (q_e.size() == 0 && q_o.size() == 0 && xv_w == 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain", ok, 1);
        chk("drain_left", q_e.size() + q_o.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
